// File: rtl/sap_pkg.sv
// Shared definitions for the program/data RAM access path: arbiter FSM states
// and the default RAM geometry.
package sap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int RAM_ADDR_WIDTH = 4;
    localparam int DATA_WIDTH     = 8;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: packed per-requester request fields
// plus the grant/ack/read-data return path.
interface ram_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = sap_pkg::RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = sap_pkg::DATA_WIDTH
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, ack, rdata, busy
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, ack, rdata, busy
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping
// from NUM_REQ-1 back to 0.
module rr_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   win,
    output logic               any_req
);

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        win     = '0;
        any_req = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == (int'(last_grant) + k) % NUM_REQ && req[j]) begin
                    win = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port program/data RAM between NUM_REQ
// requesters; each grant runs IDLE -> ACCESS -> RESP.
module ram_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = sap_pkg::RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = sap_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_arbiter_if.slave          bus,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sap_pkg::arb_state_t state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    pick;
    logic                any_req;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (bus.req),
        .last_grant (last_q),
        .win        (pick),
        .any_req    (any_req)
    );

    // Outputs are computed for the *next* state so they come straight off flops.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        gnt_d   = '0;
        ack_d   = '0;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            sap_pkg::IDLE: begin
                if (any_req) begin
                    state_d     = sap_pkg::ACCESS;
                    win_d       = pick;
                    last_d      = pick;
                    gnt_d[pick] = 1'b1;
                    busy_d      = 1'b1;
                    we_d        = bus.req_we[pick];
                end
            end
            sap_pkg::ACCESS: begin
                state_d      = sap_pkg::RESP;
                gnt_d[win_q] = 1'b1;
                ack_d[win_q] = 1'b1;
                busy_d       = 1'b1;
            end
            default: state_d = sap_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= sap_pkg::IDLE;
            win_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
        end
    end

    // Address/data follow the winner only in ACCESS; zero otherwise.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == sap_pkg::ACCESS) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_q == IDX_W'(i)) begin
                    ram_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign ram_we    = we_q;
    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = (state_q == sap_pkg::RESP) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a 2-requester and a 4-requester instance, each
// backed by a small behavioural 16x8 RAM with registered read.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(8)) bus2 ();
    ram_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8)) bus4 ();

    logic       we2, we4;
    logic [3:0] addr2, addr4;
    logic [7:0] wdata2, wdata4, rdata2, rdata4;
    logic [7:0] mem2 [16];
    logic [7:0] mem4 [16];

    ram_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(8)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .ram_we(we2), .ram_addr(addr2), .ram_wdata(wdata2), .ram_rdata(rdata2)
    );

    ram_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4),
        .ram_we(we4), .ram_addr(addr4), .ram_wdata(wdata4), .ram_rdata(rdata4)
    );

    // RAM models: write on the edge, read register shows post-write content.
    always @(posedge clk) begin
        if (we2) mem2[addr2] <= wdata2;
        rdata2 <= we2 ? wdata2 : mem2[addr2];
        if (we4) mem4[addr4] <= wdata4;
        rdata4 <= we4 ? wdata4 : mem4[addr4];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_zero2(input string tag);
        chk({tag, "_gnt"},   32'(bus2.gnt),   0);
        chk({tag, "_ack"},   32'(bus2.ack),   0);
        chk({tag, "_busy"},  32'(bus2.busy),  0);
        chk({tag, "_we"},    32'(we2),        0);
        chk({tag, "_addr"},  32'(addr2),      0);
        chk({tag, "_wdata"}, 32'(wdata2),     0);
        chk({tag, "_rdata"}, 32'(bus2.rdata), 0);
    endtask

    task automatic set_req2(input int idx, input logic we, input logic [3:0] a, input logic [7:0] d);
        bus2.req[idx]               = 1'b1;
        bus2.req_we[idx]            = we;
        bus2.req_addr[idx*4 +: 4]   = a;
        bus2.req_wdata[idx*8 +: 8]  = d;
    endtask

    // One uncontended access on bus2, entered and left at an IDLE negedge.
    task automatic access2(input string tag, input int idx, input logic we,
                           input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        set_req2(idx, we, a, d);
        @(negedge clk);
        chk({tag, "_gnt"},   32'(bus2.gnt), 32'(1 << idx));
        chk({tag, "_we"},    32'(we2),      32'(we));
        chk({tag, "_addr"},  32'(addr2),    32'(a));
        chk({tag, "_wdata"}, 32'(wdata2),   32'(d));
        chk({tag, "_ack_early"}, 32'(bus2.ack), 0);
        @(negedge clk);
        chk({tag, "_ack"},   32'(bus2.ack),   32'(1 << idx));
        chk({tag, "_rdata"}, 32'(bus2.rdata), 32'(exp_rd));
        chk({tag, "_we_resp"}, 32'(we2), 0);
        bus2.req[idx] = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(bus2.busy), 0);
        chk({tag, "_idle_we"},   32'(we2), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nack;
        int win_log [8];
        int cyc_log [8];
        int cyc;

        for (int i = 0; i < 16; i++) begin
            mem2[i] = 8'h00;
            mem4[i] = 8'h00;
        end
        bus2.req = '0; bus2.req_we = '0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus4.req = '0; bus4.req_we = '0; bus4.req_addr = '0; bus4.req_wdata = '0;

        // Reset state
        @(negedge clk);
        chk_zero2("rst");
        chk("rst_busy4", 32'(bus4.busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: write then read back
        access2("t1_wr", 0, 1'b1, 4'h3, 8'hA5, 8'hA5);
        access2("t1_rd", 0, 1'b0, 4'h3, 8'h00, 8'hA5);

        // 2: contention from reset, round-robin with 3-cycle ack spacing
        reset = 1'b0;
        set_req2(0, 1'b0, 4'h3, 8'h00);
        set_req2(1, 1'b0, 4'h3, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        nack = 0;
        cyc  = 0;
        while (cyc < 20 && nack < 4) begin
            @(negedge clk);
            cyc++;
            if (bus2.ack != 0) begin
                win_log[nack] = bus2.ack[1] ? 1 : 0;
                cyc_log[nack] = cyc;
                nack++;
            end
        end
        bus2.req = '0;
        @(negedge clk);
        chk("t2_nack", 32'(nack), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_order%0d", k), 32'(win_log[k]), 32'(k % 2));
            if (k > 0) chk($sformatf("t2_space%0d", k), 32'(cyc_log[k] - cyc_log[k-1]), 3);
        end

        // 3: req1 write (last_grant=0) ahead of req0 read of same address
        access2("t3_pre", 0, 1'b0, 4'h3, 8'h00, 8'hA5);
        set_req2(1, 1'b1, 4'hF, 8'h3C);
        set_req2(0, 1'b0, 4'hF, 8'h00);
        @(negedge clk);
        chk("t3_gnt1",   32'(bus2.gnt), 2);
        chk("t3_we1",    32'(we2), 1);
        chk("t3_addr1",  32'(addr2), 32'h0F);
        chk("t3_wdata1", 32'(wdata2), 32'h3C);
        @(negedge clk);
        chk("t3_ack1", 32'(bus2.ack), 2);
        bus2.req[1] = 1'b0;
        @(negedge clk);
        chk("t3_gap_gnt", 32'(bus2.gnt), 0);
        @(negedge clk);
        chk("t3_gnt0", 32'(bus2.gnt), 1);
        chk("t3_we0",  32'(we2), 0);
        @(negedge clk);
        chk("t3_ack0",   32'(bus2.ack), 1);
        chk("t3_rdata0", 32'(bus2.rdata), 32'h3C);
        bus2.req = '0;
        @(negedge clk);

        // 4: asynchronous reset during a write ACCESS
        set_req2(1, 1'b1, 4'h5, 8'h77);
        @(negedge clk);
        chk("t4_gnt", 32'(bus2.gnt), 2);
        chk("t4_we",  32'(we2), 1);
        #2 reset = 1'b0;
        #1 chk_zero2("t4_async");
        set_req2(0, 1'b0, 4'h3, 8'h00);
        @(negedge clk);
        chk("t4_noack", 32'(bus2.ack), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_first", 32'(bus2.gnt), 1);
        @(negedge clk);
        chk("t4_ack",   32'(bus2.ack), 1);
        chk("t4_rdata", 32'(bus2.rdata), 32'hA5);
        bus2.req = '0;
        @(negedge clk);

        // 5: request withdrawn during ACCESS still completes
        set_req2(0, 1'b0, 4'hF, 8'h00);
        @(negedge clk);
        chk("t5_gnt", 32'(bus2.gnt), 1);
        bus2.req[0] = 1'b0;
        @(negedge clk);
        chk("t5_ack",   32'(bus2.ack), 1);
        chk("t5_rdata", 32'(bus2.rdata), 32'h3C);
        @(negedge clk);
        chk("t5_idle_busy", 32'(bus2.busy), 0);
        @(negedge clk);
        chk("t5_nogrant", 32'(bus2.gnt), 0);
        chk("t5_noack",   32'(bus2.ack), 0);

        // 6: four requesters all asserting
        bus4.req = 4'hF;
        bus4.req_addr = 16'h3210;
        nack = 0;
        cyc  = 0;
        while (cyc < 30 && nack < 5) begin
            @(negedge clk);
            cyc++;
            chk("t6_onehot", 32'($onehot0(bus4.gnt)), 1);
            chk("t6_busy",   32'(bus4.busy), 32'(|bus4.gnt));
            if (bus4.ack != 0) begin
                win_log[nack] = 0;
                for (int i = 0; i < 4; i++) if (bus4.ack[i]) win_log[nack] = i;
                nack++;
            end
        end
        bus4.req = '0;
        @(negedge clk);
        chk("t6_nack", 32'(nack), 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t6_order%0d", k), 32'(win_log[k]), 32'(k % 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port program/data RAM (16 x 8, synchronous write, registered read) between NUM_REQ requesters, for example the CPU control path and a debug/program loader. Requests are arbitrated round-robin, and each granted access runs a fixed three-state sequence. The block sits between the requesters and the `ram` instance and owns the RAM's `we`, `address` and `data_in` pins.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `ADDR_WIDTH`, default 4: RAM address width.
- `DATA_WIDTH`, default 8: RAM data width.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, NUM_REQ: per-requester request level.
- `req_we`, input, NUM_REQ: 1 = write, 0 = read.
- `req_addr`, input, NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`, input, NUM_REQ*DATA_WIDTH: packed write data, packed the same way.
- `gnt`, output, NUM_REQ: one-hot; set for the winner during ACCESS and RESP.
- `ack`, output, NUM_REQ: one-hot one-cycle pulse to the winner in RESP.
- `rdata`, output, DATA_WIDTH: read data; valid only while `ack` is high.
- `busy`, output, 1: high in ACCESS and RESP.
- `ram_we`, output, 1: RAM write enable.
- `ram_addr`, output, ADDR_WIDTH: RAM address.
- `ram_wdata`, output, DATA_WIDTH: RAM write data.
- `ram_rdata`, input, DATA_WIDTH: RAM registered read data.

## Operation
The arbiter has three states: IDLE, ACCESS and RESP.

- **IDLE.** If any `req` bit is high, choose the winner round-robin. The search starts at `last_grant`+1 and wraps from NUM_REQ-1 to 0. Latch the winner index and update `last_grant`, then go to ACCESS. If no request is pending, stay in IDLE.
- **ACCESS.** `gnt[win]`=1.
  - `ram_addr` and `ram_wdata` are combinational selects of the winner's slices.
  - `ram_we`=`req_we[win]`.
  - The RAM writes, or registers its read, on the closing edge of this cycle. Next state is RESP.
- **RESP.**
  - `ack[win]`=1 and `gnt[win]`=1.
  - `rdata`=`ram_rdata`; it carries the data for both reads and writes (post-write content).
  - `ram_we`=0. Next state is IDLE, unconditionally.
- **Requester rules.** Hold `req`, `req_we`, `req_addr` and `req_wdata` stable from assertion until the `ack` cycle. Deassert `req` in the cycle after `ack`, or keep it high to request a new access.
- **Dropped request.** If `req` drops during ACCESS or RESP, the access still completes and `ack` is still pulsed. A request must not be withdrawn, so this is a protocol error.
- **Width rules.** No arithmetic on data. The winner index is clog2(NUM_REQ) bits wide, and the round-robin pointer wraps modulo NUM_REQ.
- **Simultaneous requests.** The lowest index after `last_grant` wins. A requester that keeps `req` asserted is never starved: worst-case wait is (NUM_REQ-1) accesses.

## Timing
- **Reset values.** State=IDLE and `last_grant`=NUM_REQ-1, so requester 0 wins the first contested arbitration. All outputs are 0: `gnt`, `ack`, `busy`, `ram_we`, `ram_addr`, `ram_wdata`, `rdata`.
- **IDLE output values.** `ram_addr`=0, `ram_wdata`=0, `ram_we`=0, `rdata`=0.
- **Latency.** `req` sampled high at edge N means ACCESS in cycle N+1 and `ack` in cycle N+2.
- **Throughput.** One access per 3 cycles: IDLE, ACCESS, RESP.
- **Output registering.** `gnt`, `ack`, `busy` and `ram_we` are decoded from registered state only; they have no combinational path from `req`.
- **Reset mid-operation.** Asserting `reset` in ACCESS or RESP immediately forces IDLE and clears all outputs asynchronously, including `ram_we`. No `ack` is issued for the aborted access. Before reset releases, the RAM may or may not have already written.

## Structure
- **Shared package `sap_pkg`.** Add:
  - the state enum `arb_state_t` (IDLE, ACCESS, RESP);
  - default widths: `RAM_ADDR_WIDTH`=4, `DATA_WIDTH`=8.
- **Sub-module `rr_picker`.** A combinational round-robin priority picker. Inputs: `req` vector and `last_grant` index. Outputs: winner index and `any_req`. The FSM and mux stay in `ram_arbiter`.

## Test plan
1. **Single write then read (NUM_REQ=2).**
   - Stimulus: req0 write addr 0x3 data 0xA5, then req0 read addr 0x3.
   - Required: `ram_we`=1 for exactly one cycle.
   - Required: second `ack[0]` returns `rdata`=0xA5, with `ack[0]` high 2 cycles after each `req` is sampled.
2. **Contention, round-robin.**
   - Stimulus: req0 and req1 held high from reset, 4 accesses.
   - Required: grant order 0, 1, 0, 1.
   - Required: `ack` cycles spaced exactly 3 clocks apart.
3. **Write/read isolation.**
   - Stimulus: req1 writes 0x3C to addr 0xF while req0 waits to read addr 0xF.
   - Required: req1 is serviced first only if `last_grant`=0.
   - Required: req0 then reads 0x3C.
4. **Reset during ACCESS.**
   - Stimulus: `reset` low asynchronously mid-ACCESS of a write.
   - Required: all outputs 0 within the same cycle, no `ack`.
   - Required: after release, requester 0 wins first.
5. **Request dropped in ACCESS.**
   - Stimulus: req0 deasserted during ACCESS.
   - Required: `ack[0]` still pulses in RESP.
   - Required: IDLE follows, with no further grant.
6. **NUM_REQ=4, all requesting.**
   - Stimulus: all four requesters held high.
   - Required: grants 0, 1, 2, 3, 0.
   - Required: `gnt` is always one-hot or zero, and `busy` equals |`gnt`.
